// File: rtl/matvec_pkg.sv
// matvec_pkg: shared defaults, loader FSM states and frame-size helper
package matvec_pkg;
  localparam int WIDTH_D = 32;
  localparam int ROWS_D  = 2;
  localparam int COLS_D  = 2;
  typedef enum logic {LOAD, HOLD} state_t;
  function automatic int total(input int rows, input int cols);
    return rows * cols + cols;
  endfunction
endpackage

// File: rtl/operand_bank.sv
// operand_bank: flat register array holding one matrix (row-major) plus one vector
// ports: clk, reset (async, high), clr (sync clear), we/idx/din (indexed write),
//        ld/ld_q (parallel load of a whole frame), q (stored frame)
module operand_bank import matvec_pkg::*; #(
  parameter int WIDTH = WIDTH_D,
  parameter int ROWS  = ROWS_D,
  parameter int COLS  = COLS_D,
  localparam int N    = total(ROWS, COLS),
  localparam int IW   = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             we,
  input  logic [IW-1:0]    idx,
  input  logic [WIDTH-1:0] din,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_q [N],
  output logic [WIDTH-1:0] q [N]
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '{default: '0};
    else if (clr) q <= '{default: '0};
    else if (ld) q <= ld_q;
    else if (we) q[idx] <= din;
endmodule

// File: rtl/matvec_operand_loader.sv
// matvec_operand_loader: assembles a serial element stream into a matrix and vector for the multiplier
// ports: clk, reset (async, high); in_data/in_valid/in_last/in_ready stream input;
//        matrix_out/vector_out/out_valid/out_ack frame output; frame_err error pulse
// option: MATVEC_LOADER_DBLBUF_EN adds a load bank so the next frame streams in during HOLD
module matvec_operand_loader import matvec_pkg::*; #(
  parameter int WIDTH = WIDTH_D,
  parameter int ROWS  = ROWS_D,
  parameter int COLS  = COLS_D
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] matrix_out [ROWS][COLS],
  output logic [WIDTH-1:0] vector_out [COLS],
  output logic             out_valid,
  input  logic             out_ack,
  output logic             frame_err
);
  localparam int N  = total(ROWS, COLS);
  localparam int IW = $clog2(N);
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [WIDTH-1:0] st [N];
  logic [WIDTH-1:0] ld_q [N];
  logic [WIDTH-1:0] q [N];
  logic acc, is_last, fin, err, ld, rdy_n;
  assign acc     = in_valid && in_ready;
  assign is_last = idx == IW'(N - 1);
  assign fin     = acc && in_last && is_last;
  assign err     = acc && (in_last != is_last);
  assign out_valid = state == HOLD;
`ifdef MATVEC_LOADER_DBLBUF_EN
  logic full, full_n;
  // staging doubles as the load bank; a framing error wipes the partial frame
  operand_bank #(.WIDTH(WIDTH), .ROWS(ROWS), .COLS(COLS)) u_load (
    .clk, .reset, .clr(err), .we(acc), .idx, .din(in_data),
    .ld(1'b0), .ld_q, .q(st)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) full <= 1'b0;
    else full <= full_n;
`else
  // staging keeps the outputs frozen while a frame is still arriving
  always_ff @(posedge clk or posedge reset)
    if (reset) st <= '{default: '0};
    else if (acc) st[idx] <= in_data;
`endif
  always_comb begin
    ld_q = st;
    ld_q[N-1] = fin ? in_data : st[N-1];
    idx_n = (fin || err) ? '0 : acc ? idx + 1'b1 : idx;
`ifdef MATVEC_LOADER_DBLBUF_EN
    ld = full ? (state == LOAD || out_ack) : (state == LOAD && fin);
`else
    ld = state == LOAD && fin;
`endif
    state_n = ld ? HOLD : (state == HOLD && out_ack) ? LOAD : state;
`ifdef MATVEC_LOADER_DBLBUF_EN
    full_n = ld ? 1'b0 : (state == HOLD && fin) ? 1'b1 : full;
    rdy_n = !full_n;
`else
    rdy_n = state_n == LOAD;
`endif
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= LOAD;
      idx       <= '0;
      in_ready  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      in_ready  <= rdy_n;
      frame_err <= err;
    end
  operand_bank #(.WIDTH(WIDTH), .ROWS(ROWS), .COLS(COLS)) u_out (
    .clk, .reset, .clr(1'b0), .we(1'b0), .idx('0), .din('0),
    .ld, .ld_q, .q
  );
  for (genvar i = 0; i < ROWS; i++)
    for (genvar j = 0; j < COLS; j++)
      assign matrix_out[i][j] = q[i*COLS+j];
  for (genvar j = 0; j < COLS; j++)
    assign vector_out[j] = q[ROWS*COLS+j];
endmodule

// File: tb/tb_matvec_operand_loader.sv
// tb_matvec_operand_loader: directed self-checking bench for matvec_operand_loader
module tb_matvec_operand_loader;
`ifdef MATVEC_LOADER_DBLBUF_EN
  localparam logic HOLD_RDY = 1'b1;
`else
  localparam logic HOLD_RDY = 1'b0;
`endif
  logic clk = 0, reset = 1, in_valid = 0, in_last = 0, out_ack = 0;
  logic [31:0] in_data = 0;
  logic in_ready, out_valid, frame_err;
  logic [31:0] m [2][2];
  logic [31:0] v [2];
  int total = 0, bad = 0, errs = 0, e0 = 0;
  always #5 clk = ~clk;
  always @(negedge clk) if (frame_err) errs++;
  matvec_operand_loader #(.WIDTH(32), .ROWS(2), .COLS(2)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .matrix_out(m), .vector_out(v),
    .out_valid(out_valid), .out_ack(out_ack), .frame_err(frame_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_frame(input string tag, input int b, input int s);
    chk({tag, ".m00"}, m[0][0], b);
    chk({tag, ".m01"}, m[0][1], b + s);
    chk({tag, ".m10"}, m[1][0], b + 2 * s);
    chk({tag, ".m11"}, m[1][1], b + 3 * s);
    chk({tag, ".v0"}, v[0], b + 4 * s);
    chk({tag, ".v1"}, v[1], b + 5 * s);
  endtask
  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    in_data = d;
    in_valid = 1;
    in_last = l;
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 0;
    in_last = 0;
  endtask
  task automatic ack();
    out_ack = 1;
    @(posedge clk); #1;
    out_ack = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    #12;
    chk("rst_ready", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_err", frame_err, 0);
    chk_frame("rst", 0, 0);
    reset = 0;
    @(posedge clk); #1;
    chk("ready_rise", in_ready, 1);
    chk("idle_valid", out_valid, 0);
    for (int i = 1; i <= 6; i++) send(i, i == 6);
    chk("s1_valid", out_valid, 1);
    chk("s1_ready", in_ready, HOLD_RDY);
    chk("s1_err", frame_err, 0);
    chk_frame("s1", 1, 1);
    ack();
    chk("s2_valid", out_valid, 0);
    chk("s2_ready", in_ready, 1);
    chk_frame("s2_keep", 1, 1);
    for (int i = 7; i <= 9; i++) send(i, 0);
    chk("s2_mid_valid", out_valid, 0);
    chk_frame("s2_mid", 1, 1);
    for (int i = 10; i <= 12; i++) send(i, i == 12);
    chk("s2_valid2", out_valid, 1);
    chk_frame("s2", 7, 1);
    ack();
    e0 = errs;
    for (int i = 1; i <= 3; i++) send(i, i == 3);
    chk("s3_err_pulse", frame_err, 1);
    chk("s3_err_valid", out_valid, 0);
    chk_frame("s3_keep", 7, 1);
    send(10, 0);
    chk("s3_err_drop", frame_err, 0);
    for (int i = 11; i <= 15; i++) send(i, i == 15);
    chk("s3_valid", out_valid, 1);
    chk("s3_err_count", errs - e0, 1);
    chk_frame("s3", 10, 1);
    ack();
    for (int i = 0; i < 6; i++) send(40 + i, 0);
    chk("s3b_err_pulse", frame_err, 1);
    chk("s3b_valid", out_valid, 0);
    chk_frame("s3b_keep", 10, 1);
    ack();
    chk("stray_ack_valid", out_valid, 0);
    chk("stray_ack_ready", in_ready, 1);
    for (int i = 20; i <= 23; i++) send(i, 0);
    #2 reset = 1;
    #1;
    chk("s4_rst_valid", out_valid, 0);
    chk("s4_rst_ready", in_ready, 0);
    chk("s4_rst_err", frame_err, 0);
    chk_frame("s4_rst", 0, 0);
    #3 reset = 0;
    for (int i = 20; i <= 25; i++) send(i, i == 25);
    chk("s4_valid", out_valid, 1);
    chk_frame("s4", 20, 1);
    ack();
    e0 = errs;
    for (int i = 1; i <= 6; i++) begin
      repeat ($urandom_range(0, 3)) begin
        in_data = $urandom;
        in_last = 1'($urandom);
        @(posedge clk); #1;
      end
      send(i, i == 6);
    end
    chk("s5_valid", out_valid, 1);
    chk("s5_no_err", errs - e0, 0);
    chk_frame("s5", 1, 1);
`ifdef MATVEC_LOADER_DBLBUF_EN
    for (int i = 7; i <= 12; i++) send(i, i == 12);
    chk("db_ready_full", in_ready, 0);
    chk("db_valid_full", out_valid, 1);
    chk_frame("db_keep", 1, 1);
    ack();
    chk("db_swap_valid", out_valid, 1);
    chk("db_swap_ready", in_ready, 1);
    chk_frame("db_swap", 7, 1);
    ack();
    chk("db_release", out_valid, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
